// File: rtl/rf_port_ctrl.sv
// Purpose : scoreboard + write-port arbiter for the 2R/1W 16x16 register file.
// Latency : stall/rdy are combinational; a granted writeback reaches the RF port 1 cycle later.
// Backpressure: decode held via stall on RAW/counter-full; writeback sources held via rdy (mem over alu, anti-starve).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   iss_*  / stall             decode issue request and hold
//   alu_*  / alu_rdy           ALU writeback request (valid/ready)
//   mem_*  / mem_rdy           memory writeback request (valid/ready)
//   rf_we, rf_dst_addr, rf_dst registered RF write port
//   busy, sb_err               per-register pending flags, sticky scoreboard underflow
module rf_port_ctrl #(
    parameter int DW     = 16,
    parameter int CW     = 2,
    parameter int STARVE = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_vld,
    input  logic          iss_re0,
    input  logic          iss_re1,
    input  logic [3:0]    iss_src0,
    input  logic [3:0]    iss_src1,
    input  logic          iss_we,
    input  logic [3:0]    iss_dst,
    output logic          stall,
    input  logic          alu_vld,
    input  logic [3:0]    alu_dst,
    input  logic [DW-1:0] alu_data,
    output logic          alu_rdy,
    input  logic          mem_vld,
    input  logic [3:0]    mem_dst,
    input  logic [DW-1:0] mem_data,
    output logic          mem_rdy,
    output logic          rf_we,
    output logic [3:0]    rf_dst_addr,
    output logic [DW-1:0] rf_dst,
    output logic [15:0]   busy,
    output logic          sb_err
);

    localparam int            SW       = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [CW-1:0] PEND_MAX = '1;

    logic [CW-1:0] pend     [16];
    logic [CW-1:0] pend_nxt [16];
    logic [SW-1:0] starve_cnt;

    logic          raw0, raw1, dst_full, issue_wr;
    logic          mem_gnt, alu_gnt, wb_go, wb_err;
    logic [3:0]    wb_dst;
    logic [DW-1:0] wb_data;
    logic [15:0]   inc_vec, dec_vec;

    // Hazard detection; R0 never carries a dependency.
    always_comb begin
        raw0     = iss_re0 && (iss_src0 != 4'd0) && (pend[iss_src0] != '0);
        raw1     = iss_re1 && (iss_src1 != 4'd0) && (pend[iss_src1] != '0);
        dst_full = iss_we  && (iss_dst  != 4'd0) && (pend[iss_dst] == PEND_MAX);
        stall    = iss_vld && (raw0 || raw1 || dst_full);
        issue_wr = iss_vld && !stall && iss_we && (iss_dst != 4'd0);
    end

    // Mem wins by default; once the ALU has lost STARVE times in a row it wins
    // the next contested cycle. rdy is forced low while reset is asserted.
    always_comb begin
        mem_gnt = rst_n && mem_vld && !(alu_vld && (starve_cnt == SW'(STARVE)));
        alu_gnt = rst_n && alu_vld && !mem_gnt;
        alu_rdy = alu_gnt;
        mem_rdy = mem_gnt;
        wb_go   = mem_gnt || alu_gnt;
        wb_dst  = mem_gnt ? mem_dst  : alu_dst;
        wb_data = mem_gnt ? mem_data : alu_data;
        // A writeback to a register with nothing pending is only legal if the
        // matching issue happens in the very same cycle.
        wb_err  = wb_go && (wb_dst != 4'd0) && (pend[wb_dst] == '0) &&
                  !(issue_wr && (iss_dst == wb_dst));
    end

    // Counter update: issue increments, an RF write in progress decrements,
    // both together cancel; decrement saturates at zero.
    always_comb begin
        busy = '0;
        for (int r = 0; r < 16; r++) begin
            inc_vec[r]  = issue_wr && (iss_dst == 4'(r));
            dec_vec[r]  = rf_we && (rf_dst_addr == 4'(r));
            pend_nxt[r] = pend[r];
            if (r == 0) begin
                pend_nxt[r] = '0;
            end else if (inc_vec[r] && !dec_vec[r]) begin
                pend_nxt[r] = pend[r] + CW'(1);
            end else if (dec_vec[r] && !inc_vec[r] && (pend[r] != '0)) begin
                pend_nxt[r] = pend[r] - CW'(1);
            end
            busy[r] = (r != 0) && (pend[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= '{default: '0};
            rf_we       <= 1'b0;
            rf_dst_addr <= 4'd0;
            rf_dst      <= '0;
            starve_cnt  <= '0;
            sb_err      <= 1'b0;
        end else begin
            pend  <= pend_nxt;
            // Writebacks to R0 are consumed without touching the RF port.
            rf_we <= wb_go && (wb_dst != 4'd0);
            if (wb_go && (wb_dst != 4'd0)) begin
                rf_dst_addr <= wb_dst;
                rf_dst      <= wb_data;
            end
            if (!alu_vld || alu_gnt) begin
                starve_cnt <= '0;
            end else if (mem_gnt) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
            if (wb_err) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_port_ctrl.sv
// Purpose : self-checking bench for rf_port_ctrl (directed scenarios + random traffic).
// Latency : checks comb outputs 2 time units after an edge, registered outputs 1 unit after.
// Backpressure: requesters hold vld/dst/data until rdy; decode holds a stalled instruction.
module tb_rf_port_ctrl;

    localparam int DW     = 16;
    localparam int CW     = 2;
    localparam int STARVE = 3;
    localparam int PMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iss_vld, iss_re0, iss_re1, iss_we;
    logic [3:0]    iss_src0, iss_src1, iss_dst;
    logic          stall;
    logic          alu_vld, alu_rdy, mem_vld, mem_rdy;
    logic [3:0]    alu_dst, mem_dst;
    logic [DW-1:0] alu_data, mem_data;
    logic          rf_we;
    logic [3:0]    rf_dst_addr;
    logic [DW-1:0] rf_dst;
    logic [15:0]   busy;
    logic          sb_err;

    always #5 clk = ~clk;

    rf_port_ctrl #(.DW(DW), .CW(CW), .STARVE(STARVE)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_vld(iss_vld), .iss_re0(iss_re0), .iss_re1(iss_re1),
        .iss_src0(iss_src0), .iss_src1(iss_src1), .iss_we(iss_we), .iss_dst(iss_dst),
        .stall(stall),
        .alu_vld(alu_vld), .alu_dst(alu_dst), .alu_data(alu_data), .alu_rdy(alu_rdy),
        .mem_vld(mem_vld), .mem_dst(mem_dst), .mem_data(mem_data), .mem_rdy(mem_rdy),
        .rf_we(rf_we), .rf_dst_addr(rf_dst_addr), .rf_dst(rf_dst),
        .busy(busy), .sb_err(sb_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: writes in flight per register, consecutive ALU losses,
    // sticky error, and the expected RF port contents.
    int            mp [16];
    int            mst;
    bit            msb;
    bit            mwe;
    logic [3:0]    maddr;
    logic [DW-1:0] mdat;
    bit            last_stall, last_ag, last_mg;
    int            q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++) mp[r] = 0;
        mst = 0; msb = 0; mwe = 0; maddr = '0; mdat = '0;
    endtask

    function automatic bit m_stall();
        bit s = 0;
        if (iss_vld) begin
            if (iss_re0 && iss_src0 != 0 && mp[iss_src0] > 0) s = 1;
            if (iss_re1 && iss_src1 != 0 && mp[iss_src1] > 0) s = 1;
            if (iss_we  && iss_dst  != 0 && mp[iss_dst] >= PMAX) s = 1;
        end
        return s;
    endfunction

    function automatic logic [15:0] m_busy();
        logic [15:0] b = '0;
        for (int r = 1; r < 16; r++) b[r] = (mp[r] > 0);
        return b;
    endfunction

    task automatic idle();
        iss_vld = 0; iss_re0 = 0; iss_re1 = 0; iss_we = 0;
        iss_src0 = '0; iss_src1 = '0; iss_dst = '0;
        alu_vld = 0; alu_dst = '0; alu_data = '0;
        mem_vld = 0; mem_dst = '0; mem_data = '0;
    endtask

    task automatic set_iss(input bit re0, input int s0, input bit we, input int d);
        iss_vld = 1; iss_re0 = re0; iss_src0 = 4'(s0); iss_re1 = 0; iss_src1 = '0;
        iss_we = we; iss_dst = 4'(d);
    endtask

    // One clock of traffic: inputs already driven at posedge+1.
    task automatic cycle();
        bit            st, ag, mg, issue, go;
        logic [3:0]    wd;
        logic [DW-1:0] wdat;
        int            nmp [16];
        #1;
        st = m_stall();
        mg = mem_vld && !(alu_vld && mst == STARVE);
        ag = alu_vld && !mg;
        chk("stall", stall, st);
        chk("alu_rdy", alu_rdy, ag);
        chk("mem_rdy", mem_rdy, mg);
        last_stall = st; last_ag = ag; last_mg = mg;
        go    = ag || mg;
        wd    = mg ? mem_dst : alu_dst;
        wdat  = mg ? mem_data : alu_data;
        issue = iss_vld && !st && iss_we && iss_dst != 0;
        if (go && wd != 0 && mp[wd] == 0 && !(issue && iss_dst == wd)) msb = 1;
        for (int r = 0; r < 16; r++) begin
            nmp[r] = mp[r] + ((issue && iss_dst == r) ? 1 : 0) - ((mwe && maddr == r) ? 1 : 0);
            if (nmp[r] < 0) nmp[r] = 0;
        end
        mp = nmp;
        if (issue) q.push_back(int'(iss_dst));
        if (go && wd != 0) begin
            mwe = 1; maddr = wd; mdat = wdat;
        end else begin
            mwe = 0;
        end
        if (!alu_vld || ag) mst = 0;
        else if (mg) mst++;
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, mwe);
        chk("rf_dst_addr", rf_dst_addr, maddr);
        chk("rf_dst", rf_dst, mdat);
        chk("busy", busy, m_busy());
        chk("sb_err", sb_err, msb);
    endtask

    initial begin
        int pat [6] = '{1, 1, 1, 0, 1, 1};
        idle();
        model_reset();
        rst_n = 0;
        #12 rst_n = 1;
        @(posedge clk);
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_addr", rf_dst_addr, 0);
        chk("rst_data", rf_dst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sb_err", sb_err, 0);
        chk("rst_stall", stall, 0);

        // RAW on R3 with the ALU writeback held off for 4 cycles.
        set_iss(0, 0, 1, 3);
        cycle();
        set_iss(1, 3, 0, 0);
        repeat (4) begin
            #1 chk("t1_hold_stall", stall, 1);
            cycle();
        end
        alu_vld = 1; alu_dst = 4'd3; alu_data = 16'h1234;
        #1 chk("t1_wb_stall", stall, 1);
        chk("t1_alu_rdy", alu_rdy, 1);
        cycle();
        alu_vld = 0;
        chk("t1_rf_we", rf_we, 1);
        chk("t1_rf_addr", rf_dst_addr, 3);
        #1 chk("t1_rfw_stall", stall, 1);
        cycle();
        #1 chk("t1_issue", stall, 0);
        chk("t1_busy3", busy[3], 0);
        cycle();
        idle();

        // Counter saturation on R5.
        set_iss(0, 0, 1, 5);
        repeat (3) cycle();
        chk("t2_busy5", busy[5], 1);
        #1 chk("t2_full_stall", stall, 1);
        cycle();
        mem_vld = 1; mem_dst = 4'd5; mem_data = 16'h0055;
        cycle();
        mem_vld = 0;
        #1 chk("t2_rfw_stall", stall, 1);
        cycle();
        #1 chk("t2_after_wb", stall, 0);
        cycle();
        idle();
        mem_vld = 1; mem_dst = 4'd5;
        repeat (3) cycle();
        mem_vld = 0;
        repeat (2) cycle();
        chk("t2_drained", busy[5], 0);

        // Both writeback sources contending (R0 targets leave the scoreboard alone).
        alu_vld = 1; alu_dst = 4'd0; alu_data = 16'hAAAA;
        mem_vld = 1; mem_dst = 4'd0; mem_data = 16'h5555;
        for (int i = 0; i < 6; i++) begin
            #1 chk("t3_mem_rdy", mem_rdy, pat[i]);
            chk("t3_alu_rdy", alu_rdy, 1 - pat[i]);
            cycle();
        end
        idle();
        cycle();

        // Same-edge increment and decrement on R7.
        set_iss(0, 0, 1, 7);
        cycle();
        idle();
        mem_vld = 1; mem_dst = 4'd7; mem_data = 16'h0077;
        cycle();
        mem_vld = 0;
        set_iss(0, 0, 1, 7);
        #1 chk("t4_no_stall", stall, 0);
        cycle();
        idle();
        chk("t4_busy7", busy[7], 1);
        mem_vld = 1; mem_dst = 4'd7;
        cycle();
        mem_vld = 0;
        repeat (2) cycle();
        chk("t4_drained", busy[7], 0);

        // Writeback with nothing pending.
        mem_vld = 1; mem_dst = 4'd9; mem_data = 16'h00AB;
        cycle();
        mem_vld = 0;
        chk("t5_sb_err", sb_err, 1);
        chk("t5_rf_we", rf_we, 1);
        chk("t5_addr", rf_dst_addr, 9);
        chk("t5_data", rf_dst, 16'h00AB);
        repeat (3) cycle();
        chk("t5_sticky", sb_err, 1);

        // Reset in the middle of traffic.
        set_iss(0, 0, 1, 2);
        repeat (2) cycle();
        idle();
        mem_vld = 1; mem_dst = 4'd2; mem_data = 16'h0022;
        alu_vld = 1; alu_dst = 4'd0;
        cycle();
        chk("t6_pre_busy2", busy[2], 1);
        chk("t6_pre_we", rf_we, 1);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_we", rf_we, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_alu_rdy", alu_rdy, 0);
        chk("t6_rst_mem_rdy", mem_rdy, 0);
        chk("t6_rst_sb_err", sb_err, 0);
        model_reset();
        idle();
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        set_iss(1, 2, 0, 0);
        #1 chk("t6_read_r2", stall, 0);
        cycle();
        idle();

        // Random traffic: writebacks return the destinations of issued writes,
        // with occasional R0 writebacks mixed in.
        q.delete();
        last_stall = 0; last_ag = 0; last_mg = 0;
        for (int n = 0; n < 800; n++) begin
            if (!(iss_vld && last_stall)) begin
                iss_vld  = ($urandom_range(0, 2) != 0);
                iss_re0  = $urandom_range(0, 1) != 0;
                iss_re1  = $urandom_range(0, 1) != 0;
                iss_src0 = 4'($urandom_range(0, 7));
                iss_src1 = 4'($urandom_range(0, 7));
                iss_we   = $urandom_range(0, 1) != 0;
                iss_dst  = 4'($urandom_range(0, 7));
            end
            if (alu_vld && last_ag) alu_vld = 0;
            if (!alu_vld && $urandom_range(0, 1) != 0) begin
                if ($urandom_range(0, 9) == 0) begin
                    alu_vld = 1; alu_dst = 4'd0; alu_data = 16'($urandom);
                end else if (q.size() > 0) begin
                    alu_vld = 1; alu_dst = 4'(q.pop_front()); alu_data = 16'($urandom);
                end
            end
            if (mem_vld && last_mg) mem_vld = 0;
            if (!mem_vld && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 9) == 0) begin
                    mem_vld = 1; mem_dst = 4'd0; mem_data = 16'($urandom);
                end else if (q.size() > 0) begin
                    mem_vld = 1; mem_dst = 4'(q.pop_front()); mem_data = 16'($urandom);
                end
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
